// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: one-hot rotating priority ring, registered exclusive grant held until the owner drops req.
// Optional forced release after MAX_HOLD cycles is compiled in with `define RING_ARB_TIMEOUT_EN.
module ring_rr_arbiter #(
    parameter int N        = 8,
    parameter int ID_W     = 3,
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic [N-1:0]     ring_ptr,
    output logic             timeout,
    output logic [CNT_W-1:0] grant_cnt
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [ID_W-1:0]  gnt_id_reg, gnt_id_next;
    logic [N-1:0]     ring_ptr_reg, ring_ptr_next;
    logic [CNT_W-1:0] grant_cnt_reg, grant_cnt_next;

    logic [ID_W-1:0]  ptr_term [N];
    logic [ID_W-1:0]  ptr_idx;
    logic [N-1:0]     rot_gnt;
    logic [ID_W-1:0]  scan_idx;
    logic [ID_W-1:0]  win_idx;
    logic             win_found;
    logic             own_req;
    logic             hold_expired;

    generate
        if (N < 2 || ID_W != $clog2(N) || MAX_HOLD < 1 || HOLD_W < 1 ||
            (2 ** HOLD_W) < MAX_HOLD || CNT_W < 1) begin : g_bad_cfg
            $error("ring_rr_arbiter: inconsistent parameters");
        end
    endgenerate

    // Pointer encode and next-pointer rotation, one slice per requester.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_slice
            assign ptr_term[gi] = ring_ptr_reg[gi] ? ID_W'(gi) : '0;
            assign rot_gnt[gi]  = gnt_reg[(gi + N - 1) % N];
        end
    endgenerate

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < N; i++) begin
            ptr_idx = ptr_idx | ptr_term[i];
        end
    end

    // First requester at or above the pointer, wrapping N-1 -> 0.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = ID_W'((int'(ptr_idx) + k) % N);
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign own_req = req[gnt_id_reg];

`ifdef RING_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              timeout_reg, timeout_next;
    assign hold_expired = (hold_reg == HOLD_W'(MAX_HOLD - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            ring_ptr_reg  <= N'(1);
            grant_cnt_reg <= '0;
`ifdef RING_ARB_TIMEOUT_EN
            hold_reg      <= '0;
            timeout_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            ring_ptr_reg  <= ring_ptr_next;
            grant_cnt_reg <= grant_cnt_next;
`ifdef RING_ARB_TIMEOUT_EN
            hold_reg      <= hold_next;
            timeout_reg   <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_id_next    = gnt_id_reg;
        ring_ptr_next  = ring_ptr_reg;
        grant_cnt_next = grant_cnt_reg;
`ifdef RING_ARB_TIMEOUT_EN
        hold_next      = hold_reg;
        timeout_next   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (win_found) begin
                    state_next     = GRANT;
                    gnt_next       = N'(1) << win_idx;
                    gnt_id_next    = win_idx;
                    grant_cnt_next = grant_cnt_reg + CNT_W'(1);
`ifdef RING_ARB_TIMEOUT_EN
                    hold_next      = '0;
`endif
                end
            end
            GRANT: begin
                // A forced release looks exactly like a voluntary one, plus the pulse.
                if (!own_req || hold_expired) begin
                    state_next    = IDLE;
                    gnt_next      = '0;
                    gnt_id_next   = '0;
                    ring_ptr_next = rot_gnt;
`ifdef RING_ARB_TIMEOUT_EN
                    timeout_next  = own_req;
`endif
                end else begin
`ifdef RING_ARB_TIMEOUT_EN
                    hold_next = hold_reg + HOLD_W'(1);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        gnt       = gnt_reg;
        gnt_id    = gnt_id_reg;
        busy      = (state_reg == GRANT);
        ring_ptr  = ring_ptr_reg;
        grant_cnt = grant_cnt_reg;
`ifdef RING_ARB_TIMEOUT_EN
        timeout   = timeout_reg;
`else
        timeout   = 1'b0;
`endif
    end

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Bench for ring_rr_arbiter: directed vector table, hand sequences and randomized traffic against a queue-free owner/pointer model.
module tb_ring_rr_arbiter;

    localparam int N        = 8;
    localparam int MAX_HOLD = 16;
`ifdef RING_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  req = 8'h00;
    logic [7:0]  gnt;
    logic [2:0]  gnt_id;
    logic        busy;
    logic [7:0]  ring_ptr;
    logic        timeout;
    logic [15:0] grant_cnt;

    logic [7:0]  s_gnt;
    logic [2:0]  s_gnt_id;
    logic        s_busy;
    logic [7:0]  s_ring_ptr;
    logic        s_timeout;
    logic [3:0]  s_grant_cnt;

    ring_rr_arbiter #(.N(8), .ID_W(3), .MAX_HOLD(MAX_HOLD), .HOLD_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .ring_ptr(ring_ptr), .timeout(timeout), .grant_cnt(grant_cnt)
    );

    ring_rr_arbiter #(.N(8), .ID_W(3), .MAX_HOLD(MAX_HOLD), .HOLD_W(5), .CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .req(req), .gnt(s_gnt), .gnt_id(s_gnt_id), .busy(s_busy),
        .ring_ptr(s_ring_ptr), .timeout(s_timeout), .grant_cnt(s_grant_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: owner index (-1 when idle), priority index, grants issued, cycles held.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;
    int m_hold  = 0;
    bit m_to    = 1'b0;

    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [7:0]  gnt;
        logic [2:0]  id;
        logic        busy;
        logic [7:0]  ptr;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] q);
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0; m_hold = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++) begin
                    if (m_owner < 0 && q[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                if (m_owner >= 0) begin
                    m_cnt  = (m_cnt + 1) % 65536;
                    m_hold = 0;
                end
            end else if (!q[m_owner] || (TO_EN && m_hold == MAX_HOLD - 1)) begin
                m_to    = q[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endtask

    // One clock: drive, advance, update the model, compare every output.
    task automatic step(input logic r, input logic [7:0] q);
        logic [7:0] e_gnt;
        logic [7:0] e_ptr;
        rst = r;
        req = q;
        @(posedge clk);
        #1;
        model_step(r, q);
        e_gnt = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
        e_ptr = 8'h01 << m_ptr;
        chk("gnt", gnt, e_gnt);
        chk("gnt_id", gnt_id, (m_owner < 0) ? 0 : m_owner);
        chk("busy", busy, (m_owner >= 0));
        chk("ring_ptr", ring_ptr, e_ptr);
        chk("timeout", timeout, m_to);
        chk("grant_cnt", grant_cnt, m_cnt);
        chk("grant_cnt_w4", s_grant_cnt, m_cnt % 16);
        $display("cyc rst=%0b req=%02h -> gnt=%02h id=%0d busy=%0b ptr=%02h to=%0b cnt=%0d",
                 r, q, gnt, gnt_id, busy, ring_ptr, timeout, grant_cnt);
    endtask

    initial begin
        int n_own0;
        int n_to;
        logic [7:0] cur;

        tbl[0]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 8'h01, 16'd0};
        tbl[1]  = '{1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 8'h01, 16'd0};
        tbl[2]  = '{1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 8'h01, 16'd1};
        tbl[3]  = '{1'b0, 8'hFE, 8'h00, 3'd0, 1'b0, 8'h02, 16'd1};
        tbl[4]  = '{1'b0, 8'h41, 8'h40, 3'd6, 1'b1, 8'h02, 16'd2};
        tbl[5]  = '{1'b0, 8'h41, 8'h40, 3'd6, 1'b1, 8'h02, 16'd2};
        tbl[6]  = '{1'b0, 8'h01, 8'h00, 3'd0, 1'b0, 8'h80, 16'd2};
        tbl[7]  = '{1'b0, 8'h41, 8'h01, 3'd0, 1'b1, 8'h80, 16'd3};
        tbl[8]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h02, 16'd3};
        tbl[9]  = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 8'h02, 16'd4};
        tbl[10] = '{1'b1, 8'h08, 8'h00, 3'd0, 1'b0, 8'h01, 16'd0};
        tbl[11] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 8'h01, 16'd1};
        tbl[12] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h10, 16'd1};
        tbl[13] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'h10, 16'd1};

        for (int v = 0; v < 14; v++) begin
            step(tbl[v].rst, tbl[v].req);
            chk($sformatf("tbl%0d_gnt", v), gnt, tbl[v].gnt);
            chk($sformatf("tbl%0d_id", v), gnt_id, tbl[v].id);
            chk($sformatf("tbl%0d_busy", v), busy, tbl[v].busy);
            chk($sformatf("tbl%0d_ptr", v), ring_ptr, tbl[v].ptr);
            chk($sformatf("tbl%0d_cnt", v), grant_cnt, tbl[v].cnt);
        end

        // Rotation: everyone requests, each owner lets go after three granted cycles.
        step(1'b1, 8'hFF);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 8'hFF);
            chk("rot_owner", gnt_id, i % 8);
            chk("rot_gnt", gnt, 8'h01 << (i % 8));
            step(1'b0, 8'hFF);
            step(1'b0, 8'hFF);
            step(1'b0, 8'hFF & ~(8'h01 << (i % 8)));
            chk("rot_idle_gap", busy, 0);
        end
        chk("rot_count", grant_cnt, 9);

        // Hold limit: owner 0 keeps requesting next to requester 2.
        step(1'b1, 8'h05);
        n_own0 = 0;
        n_to   = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 8'h05);
            if (gnt == 8'h01) n_own0++;
            if (timeout) n_to++;
        end
        chk("hold_cycles", n_own0, TO_EN ? 16 : 20);
        chk("timeout_pulses", n_to, TO_EN ? 1 : 0);
        chk("owner_after_hold", gnt_id, TO_EN ? 2 : 0);

        // Narrow counter wrap: 17 single-cycle request pulses.
        step(1'b1, 8'h00);
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 8'h01);
            step(1'b0, 8'h00);
        end
        chk("wrap_cnt_w4", s_grant_cnt, 1);
        chk("wrap_cnt_w16", grant_cnt, 17);

        // Randomized traffic.
        step(1'b1, 8'h00);
        cur = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) cur = 8'($urandom) & 8'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 4) == 0) cur[m_owner] = 1'b0;
            step(($urandom_range(0, 63) == 0), cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one resource among N requesters.
- Priority is held in a one-hot rotating ring pointer, the same structure as the team's ring counter.
- Grants are registered and exclusive. A grant is held until the owner drops its request, or (optional) until a hold timeout.
- Sits between request sources and a shared datapath; supplies a one-hot grant, an encoded owner id and status.

Parameters:
- N, 8, number of requesters (≥2).
- ID_W, 3, width of gnt_id; must equal clog2(N).
- MAX_HOLD, 16, max consecutive cycles one owner may hold the grant (≥1; used only with the optional feature).
- HOLD_W, 5, width of hold counter; must hold MAX_HOLD.
- CNT_W, 16, width of grant counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  N  request per requester, level, held high while the resource is wanted.
- gnt  out  N  one-hot grant, registered.
- gnt_id  out  ID_W  index of the current owner; 0 when idle.
- busy  out  1  high while any grant is active.
- ring_ptr  out  N  one-hot priority pointer; its set bit marks the highest-priority requester.
- timeout  out  1  one-cycle pulse on a forced release (optional feature only).
- grant_cnt  out  CNT_W  total grants issued; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at a clk edge, including mid-grant): on that same edge gnt=0, gnt_id=0, busy=0, timeout=0, grant_cnt=0, ring_ptr=1 (bit 0), hold counter=0, state=IDLE.
- States:
  - IDLE: no grant.
  - GRANT: one owner holds the resource.
- IDLE: if req≠0 at edge t:
  - Owner = first set req bit found scanning upward from the ring_ptr bit, wrapping N-1→0.
  - gnt/gnt_id/busy assert at edge t (visible cycle t+1).
  - grant_cnt increments; hold counter clears; state goes to GRANT.
  - If req=0, stay in IDLE.
- GRANT: if req[owner]=1, hold the grant and increment the hold counter.
- GRANT, release: if req[owner]=0 at an edge:
  - gnt=0, busy=0, gnt_id=0 on that edge.
  - ring_ptr becomes the owner one-hot rotated left by 1 (bit N-1 wraps to bit 0); state goes to IDLE.
- At least one idle cycle separates consecutive grants. Re-arbitration happens in IDLE on the following edge with the new ring_ptr.
- Requests from non-owners during GRANT are ignored; they are not latched and are re-sampled in IDLE.
- An owner that re-raises req right after its release is granted again only if no requester sits between the new ring_ptr and it.
- A req pulse of one cycle in IDLE still wins a grant. The grant is then released one edge later because req is already low. This is legal.
- ring_ptr changes only on release (or reset), never while idle.
- gnt is always 0 or one-hot; gnt_id always equals the encoded gnt.
- grant_cnt wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
- Macro RING_ARB_TIMEOUT_EN.
- Defined: in GRANT, when the hold counter reaches MAX_HOLD-1 and req[owner] is still 1, the next edge forces a release, identical to a normal release, and timeout pulses high for exactly one cycle. The pre-empted requester competes again in IDLE with lowest priority.
- Not defined: no hold counter logic; timeout is tied to 0; a grant lasts until req[owner] drops.

Test Plan:
- Reset check: rst=1 for 2 cycles with req=8'hFF, then rst=0 → gnt=0, busy=0, ring_ptr=8'h01, grant_cnt=0 during reset. First grant gnt=8'h01, gnt_id=0 one cycle after rst drops.
- Rotation: req=8'hFF held, each owner drops req for 1 cycle after 3 cycles of grant → grant order 0,1,2,…,7,0. One idle cycle between grants; grant_cnt=9 after the ninth grant.
- Wrap priority: ring_ptr=8'h80 (after owner 6 releases), req=8'h41 → gnt=8'h01 (bit 0 is found via wrap before bit 6); ring_ptr then becomes 8'h02.
- Reset mid-grant: owner 3 granted, assert rst for 1 cycle → on that edge gnt=0, ring_ptr=8'h01. After rst, req=8'h08 still high → gnt=8'h08 one cycle later.
- Timeout (RING_ARB_TIMEOUT_EN, MAX_HOLD=16): req=8'h05 held constantly → owner 0 held for 16 cycles, timeout=1 for one cycle, then owner 2 granted. Without the macro, owner 0 holds indefinitely and timeout stays 0.
- Counter wrap (CNT_W=4): 17 grants → grant_cnt reads 1.
